// File: rtl/mac_sequencer.sv
// Sequences RAM/ROM reads and MAC enables for one matrix-vector product, one row at a time.
// Build option: define MAC_SEQ_RELU_EN to clamp negative row results to zero at capture.
module mac_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int ROM_AW   = 6,
  parameter int VEC_LEN  = 8,
  parameter int NUM_ROWS = 4,
  parameter int ROW_W    = 2,
  parameter int MEM_LAT  = 1,
  parameter int ACC_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              mem_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              acc_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [ROW_W-1:0]  res_row,
  output logic              done
);

  // Result handshake: a row result transfers in any cycle where res_valid && res_ready;
  // res_data/res_row stay stable while res_valid is high and res_ready is low.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    ISSUE    = 3'd2,
    DRAIN    = 3'd3,
    CAPTURE  = 3'd4,
    WAIT_ACK = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ROW_W-1:0]   row;
  logic [1:0]         drain_cnt;
  logic [MEM_LAT-1:0] re_pipe;
  logic               last_k;
  logic               drain_done;
  logic               res_fire;
  logic               last_row;
  logic [ROM_AW-1:0]  row_base;
  logic [ACC_W-1:0]   capture_val;

  // ram_addr doubles as the element index k
  assign last_k     = (ram_addr == ADDR_W'(VEC_LEN - 1));
  assign drain_done = (drain_cnt == 2'(MEM_LAT - 1));
  assign res_fire   = res_valid && res_ready;
  assign last_row   = (row == ROW_W'(NUM_ROWS - 1));
  assign row_base   = ROM_AW'(row) * ROM_AW'(VEC_LEN);
  assign mac_en     = re_pipe[MEM_LAT-1];

`ifdef MAC_SEQ_RELU_EN
  assign capture_val = acc_in[ACC_W-1] ? '0 : acc_in;
`else
  assign capture_val = acc_in;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    acc_clr   = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_re = 1'b1;
        if (last_k) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (res_fire) state_nxt = last_row ? IDLE : CLEAR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      ram_addr  <= '0;
      rom_addr  <= '0;
      drain_cnt <= '0;
      re_pipe   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == WAIT_ACK) && res_fire && last_row;
      // mac_en is mem_re seen MEM_LAT cycles later, matching read data arrival
      re_pipe[0] <= mem_re;
      for (int i = 1; i < MEM_LAT; i++) re_pipe[i] <= re_pipe[i-1];
      case (state)
        CLEAR: begin
          ram_addr <= '0;
          rom_addr <= row_base;
        end
        ISSUE: begin
          drain_cnt <= '0;
          if (!last_k) begin
            ram_addr <= ram_addr + 1'b1;
            rom_addr <= rom_addr + 1'b1;
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        CAPTURE: begin
          res_valid <= 1'b1;
          res_data  <= capture_val;
          res_row   <= row;
        end
        WAIT_ACK: begin
          if (res_fire) begin
            res_valid <= 1'b0;
            row       <= last_row ? '0 : row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: two instances (MEM_LAT 1 and 3) share stimulus; expected traces are
// derived from the row schedule (clear, issue window, capture, handshake) computed arithmetically.
module tb_mac_sequencer;

  localparam int ADDR_W   = 4;
  localparam int ROM_AW   = 6;
  localparam int VEC_LEN  = 8;
  localparam int NUM_ROWS = 4;
  localparam int ROW_W    = 2;
  localparam int ACC_W    = 12;
  localparam int MAXC     = 256;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start;
  logic             res_ready;
  logic [ACC_W-1:0] acc_in;

  logic              busy_o[2], mem_re_o[2], acc_clr_o[2], mac_en_o[2], res_valid_o[2], done_o[2];
  logic [ADDR_W-1:0] ram_addr_o[2];
  logic [ROM_AW-1:0] rom_addr_o[2];
  logic [ACC_W-1:0]  res_data_o[2];
  logic [ROW_W-1:0]  res_row_o[2];

  mac_sequencer #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW), .VEC_LEN(VEC_LEN), .NUM_ROWS(NUM_ROWS),
                  .ROW_W(ROW_W), .MEM_LAT(1), .ACC_W(ACC_W)) dut_lat1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_o[0]), .mem_re(mem_re_o[0]),
    .ram_addr(ram_addr_o[0]), .rom_addr(rom_addr_o[0]), .acc_clr(acc_clr_o[0]),
    .mac_en(mac_en_o[0]), .acc_in(acc_in), .res_valid(res_valid_o[0]), .res_ready(res_ready),
    .res_data(res_data_o[0]), .res_row(res_row_o[0]), .done(done_o[0])
  );

  mac_sequencer #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW), .VEC_LEN(VEC_LEN), .NUM_ROWS(NUM_ROWS),
                  .ROW_W(ROW_W), .MEM_LAT(3), .ACC_W(ACC_W)) dut_lat3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_o[1]), .mem_re(mem_re_o[1]),
    .ram_addr(ram_addr_o[1]), .rom_addr(rom_addr_o[1]), .acc_clr(acc_clr_o[1]),
    .mac_en(mac_en_o[1]), .acc_in(acc_in), .res_valid(res_valid_o[1]), .res_ready(res_ready),
    .res_data(res_data_o[1]), .res_row(res_row_o[1]), .done(done_o[1])
  );

  // ---------------- stimulus tables and reference model ----------------
  logic             st_v[MAXC];
  logic             rdy_v[MAXC];
  logic [ACC_W-1:0] acc_v[MAXC];

  logic              e_busy[2][MAXC], e_clr[2][MAXC], e_re[2][MAXC], e_mac[2][MAXC];
  logic              e_val[2][MAXC], e_done[2][MAXC];
  logic [ADDR_W-1:0] e_ram[2][MAXC];
  logic [ROM_AW-1:0] e_rom[2][MAXC];
  logic [ACC_W-1:0]  e_data[2][MAXC];
  logic [ROW_W-1:0]  e_row[2][MAXC];
  int                iss_k[2][MAXC];
  int                iss_r[2][MAXC];
  int                end_c[2];

  logic [ACC_W-1:0] exp_q[$];

  function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] a);
`ifdef MAC_SEQ_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  // Cycle 0 is the cycle in which start is sampled high.
  task automatic build_model(input int d, input int lat);
    int c0, v, hs;
    logic [ADDR_W-1:0] ra;
    logic [ROM_AW-1:0] ro;
    logic [ACC_W-1:0]  rd;
    logic [ROW_W-1:0]  rr;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[d][c] = 0; e_clr[d][c] = 0; e_re[d][c] = 0; e_mac[d][c] = 0;
      e_val[d][c] = 0; e_done[d][c] = 0; iss_k[d][c] = -1; iss_r[d][c] = 0;
      e_data[d][c] = '0; e_row[d][c] = '0;
    end
    c0 = 1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      e_clr[d][c0] = 1;
      for (int k = 0; k < VEC_LEN; k++) begin
        e_re[d][c0+1+k]      = 1;
        iss_k[d][c0+1+k]     = k;
        iss_r[d][c0+1+k]     = r;
        e_mac[d][c0+1+k+lat] = 1;
      end
      v  = c0 + VEC_LEN + 2 + lat;
      hs = v;
      while (!rdy_v[hs]) hs++;
      for (int c = v; c <= hs; c++) begin
        e_val[d][c]  = 1;
        e_data[d][c] = relu(acc_v[v-1]);
        e_row[d][c]  = ROW_W'(r);
      end
      if (d == 0) exp_q.push_back(relu(acc_v[v-1]));
      c0 = hs + 1;
    end
    e_done[d][c0] = 1;
    end_c[d] = c0;
    for (int c = 1; c < c0; c++) e_busy[d][c] = 1;
    // addresses and results hold their last value between updates
    ra = '0; ro = '0; rd = '0; rr = '0;
    for (int c = 0; c < MAXC; c++) begin
      if (iss_k[d][c] >= 0) begin
        ra = ADDR_W'(iss_k[d][c]);
        ro = ROM_AW'(iss_r[d][c] * VEC_LEN + iss_k[d][c]);
      end
      if (e_val[d][c]) begin
        rd = e_data[d][c];
        rr = e_row[d][c];
      end
      e_ram[d][c]  = ra;
      e_rom[d][c]  = ro;
      e_data[d][c] = rd;
      e_row[d][c]  = rr;
    end
  endtask

  // kind: 0 ready tied high with forced capture values, 1 backpressure, 2 start while busy, 3 random
  task automatic prep(input int kind);
    exp_q.delete();
    for (int c = 0; c < MAXC; c++) begin
      st_v[c]  = (c == 0);
      rdy_v[c] = (kind == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (c >= 120) rdy_v[c] = 1'b1;
      acc_v[c] = ACC_W'($urandom_range(0, (1 << ACC_W) - 1));
      if (kind == 3 && c >= 2 && c <= 30) st_v[c] = ($urandom_range(0, 2) == 0);
    end
    if (kind == 0) begin
      acc_v[11] = 12'hFF0;
      acc_v[23] = 12'h07F;
    end
    if (kind == 1) for (int c = 12; c <= 16; c++) rdy_v[c] = 1'b0;
    if (kind == 2) for (int c = 4; c <= 6; c++) st_v[c] = 1'b1;
    build_model(0, 1);
    build_model(1, 3);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_cycle(input int d, input int c, input string name);
    string p;
    p = $sformatf("%s.d%0d", name, d);
    check({p, ".busy"},      c, 32'(busy_o[d]),      32'(e_busy[d][c]));
    check({p, ".acc_clr"},   c, 32'(acc_clr_o[d]),   32'(e_clr[d][c]));
    check({p, ".mem_re"},    c, 32'(mem_re_o[d]),    32'(e_re[d][c]));
    check({p, ".mac_en"},    c, 32'(mac_en_o[d]),    32'(e_mac[d][c]));
    check({p, ".ram_addr"},  c, 32'(ram_addr_o[d]),  32'(e_ram[d][c]));
    check({p, ".rom_addr"},  c, 32'(rom_addr_o[d]),  32'(e_rom[d][c]));
    check({p, ".res_valid"}, c, 32'(res_valid_o[d]), 32'(e_val[d][c]));
    check({p, ".res_data"},  c, 32'(res_data_o[d]),  32'(e_data[d][c]));
    check({p, ".res_row"},   c, 32'(res_row_o[d]),   32'(e_row[d][c]));
    check({p, ".done"},      c, 32'(done_o[d]),      32'(e_done[d][c]));
  endtask

  task automatic check_all_zero(input string name, input int c);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.d%0d.busy", name, d),      c, 32'(busy_o[d]),      32'd0);
      check($sformatf("%s.d%0d.acc_clr", name, d),   c, 32'(acc_clr_o[d]),   32'd0);
      check($sformatf("%s.d%0d.mem_re", name, d),    c, 32'(mem_re_o[d]),    32'd0);
      check($sformatf("%s.d%0d.mac_en", name, d),    c, 32'(mac_en_o[d]),    32'd0);
      check($sformatf("%s.d%0d.ram_addr", name, d),  c, 32'(ram_addr_o[d]),  32'd0);
      check($sformatf("%s.d%0d.rom_addr", name, d),  c, 32'(rom_addr_o[d]),  32'd0);
      check($sformatf("%s.d%0d.res_valid", name, d), c, 32'(res_valid_o[d]), 32'd0);
      check($sformatf("%s.d%0d.res_data", name, d),  c, 32'(res_data_o[d]),  32'd0);
      check($sformatf("%s.d%0d.res_row", name, d),   c, 32'(res_row_o[d]),   32'd0);
      check($sformatf("%s.d%0d.done", name, d),      c, 32'(done_o[d]),      32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b0; acc_in = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_job(input string name);
    int last;
    logic [ACC_W-1:0] exp;
    last = ((end_c[0] > end_c[1]) ? end_c[0] : end_c[1]) + 2;
    for (int c = 0; c <= last; c++) begin
      start = st_v[c]; res_ready = rdy_v[c]; acc_in = acc_v[c];
      for (int d = 0; d < 2; d++) compare_cycle(d, c, name);
      if (res_valid_o[0] && res_ready) begin
        check({name, ".sb_pending"}, c, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check({name, ".sb_data"}, c, 32'(res_data_o[0]), 32'(exp));
        end
      end
      step();
    end
    start = 1'b0; res_ready = 1'b0;
    check({name, ".sb_drained"}, last, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b0; acc_in = '0;

    do_reset();
    check_all_zero("reset", 0);

    prep(0);
    run_job("basic");

    do_reset();
    prep(1);
    run_job("backpressure");

    do_reset();
    prep(2);
    run_job("start_busy");

    // reset sampled at the end of cycle 5, in the middle of the first row's reads
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    check("midrst.d0.mem_re", 5, 32'(mem_re_o[0]), 32'd1);
    check("midrst.d0.ram_addr", 5, 32'(ram_addr_o[0]), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst", 6);
    for (int c = 7; c < 20; c++) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("midrst.d%0d.mac_en", d), c, 32'(mac_en_o[d]), 32'd0);
        check($sformatf("midrst.d%0d.busy", d), c, 32'(busy_o[d]), 32'd0);
      end
      step();
    end
    prep(3);
    run_job("after_rst");

    for (int n = 0; n < 3; n++) begin
      do_reset();
      prep(3);
      run_job($sformatf("random%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
